i2s_rx_deserializer: RTL and testbench

- Upstream front end of the equalizer top level. Receives an external I2S stream (BCLK, LRCLK, SDATA), oversampled in the 50 MHz system clock domain.
- Deserializes one selected channel into 24-bit two's-complement samples.
- Presents each sample as sample_out plus a one-cycle sample_valid strobe. These drive the equalizer's audio_in/audio_valid inputs.
- Detects malformed slots and reports them on a sticky error flag.

---
 rtl/i2s_rx_deserializer.sv | 152 +++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the clk domain and delivers one
// channel as DATA_W-bit samples with a one-cycle valid strobe and a sticky slot-length error.
module i2s_rx_deserializer #(
   parameter int DATA_W  = 24,
   parameter int SLOT_W  = 32,
   parameter int CHANNEL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              i2s_bclk,
   input  logic              i2s_lrclk,
   input  logic              i2s_sdata,
   input  logic              err_clr,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(SLOT_W + 2);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_W + 1);
   localparam logic             CH_SEL   = 1'(CHANNEL);

   typedef enum logic {WAIT_SYNC, SLOT} state_t;

   logic bclk_s1_q, bclk_s1_d, bclk_s2_q, bclk_s2_d, bclk_prev_q, bclk_prev_d;
   logic lr_s1_q, lr_s1_d, lr_s2_q, lr_s2_d;
   logic sd_s1_q, sd_s1_d, sd_s2_q, sd_s2_d;
   logic rise_q, rise_d, lr_smp_q, lr_smp_d, sd_smp_q, sd_smp_d;
   logic lr_ref_q, lr_ref_d, tag_q, tag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d, shift_cur;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] sample_out_q, sample_out_d;
   logic              sample_valid_q, sample_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              lr_edge, err_set;

   always_comb begin
      bclk_s1_d      = i2s_bclk;
      bclk_s2_d      = bclk_s1_q;
      bclk_prev_d    = bclk_s2_q;
      lr_s1_d        = i2s_lrclk;
      lr_s2_d        = lr_s1_q;
      sd_s1_d        = i2s_sdata;
      sd_s2_d        = sd_s1_q;
      // Edge register: LRCLK/SDATA are pipelined alongside the rise flag so all three line up.
      rise_d         = bclk_s2_q & ~bclk_prev_q;
      lr_smp_d       = lr_s2_q;
      sd_smp_d       = sd_s2_q;
      lr_ref_d       = lr_ref_q;
      tag_d          = tag_q;
      cnt_d          = cnt_q;
      shift_d        = shift_q;
      state_d        = state_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      err_set        = 1'b0;
      lr_edge        = rise_q && (lr_smp_q != lr_ref_q);
      shift_cur      = (cnt_q < CNT_DATA) ? {shift_q[DATA_W-2:0], sd_smp_q} : shift_q;

      if (rise_q) lr_ref_d = lr_smp_q;

      if (!enable) begin
         state_d = WAIT_SYNC;
         cnt_d   = '0;
      end else begin
         case (state_q)
            WAIT_SYNC: begin
               // The old-slot bit riding on the first edge is dropped; partial slots never emit.
               if (lr_edge) begin
                  state_d = SLOT;
                  cnt_d   = '0;
                  tag_d   = lr_smp_q;
                  shift_d = '0;
               end
            end
            SLOT: begin
               if (lr_edge) begin
                  // The edge bit is the last bit of the closing slot (one-bit I2S delay).
                  if (cnt_q == CNT_LAST) begin
                     if (tag_q == CH_SEL) begin
                        sample_out_d   = shift_cur;
                        sample_valid_d = 1'b1;
                     end
                  end else begin
                     err_set = 1'b1;
                  end
                  cnt_d   = '0;
                  tag_d   = lr_smp_q;
                  shift_d = '0;
               end else if (rise_q) begin
                  shift_d = shift_cur;
                  if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = WAIT_SYNC;
         endcase
      end

      frame_err_d = err_set | (frame_err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_s1_q      <= 1'b0;
         bclk_s2_q      <= 1'b0;
         bclk_prev_q    <= 1'b0;
         lr_s1_q        <= 1'b0;
         lr_s2_q        <= 1'b0;
         sd_s1_q        <= 1'b0;
         sd_s2_q        <= 1'b0;
         rise_q         <= 1'b0;
         lr_smp_q       <= 1'b0;
         sd_smp_q       <= 1'b0;
         lr_ref_q       <= 1'b0;
         tag_q          <= 1'b0;
         cnt_q          <= '0;
         shift_q        <= '0;
         state_q        <= WAIT_SYNC;
         sample_out_q   <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         bclk_s1_q      <= bclk_s1_d;
         bclk_s2_q      <= bclk_s2_d;
         bclk_prev_q    <= bclk_prev_d;
         lr_s1_q        <= lr_s1_d;
         lr_s2_q        <= lr_s2_d;
         sd_s1_q        <= sd_s1_d;
         sd_s2_q        <= sd_s2_d;
         rise_q         <= rise_d;
         lr_smp_q       <= lr_smp_d;
         sd_smp_q       <= sd_smp_d;
         lr_ref_q       <= lr_ref_d;
         tag_q          <= tag_d;
         cnt_q          <= cnt_d;
         shift_q        <= shift_d;
         state_q        <= state_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign sample_out   = sample_out_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench: drives an I2S stream into a left-channel and a right-channel receiver
// and checks samples, latency, error flag, enable and reset behaviour.
module tb_i2s_rx_deserializer;

   localparam int HALF   = 8;
   localparam int K_NONE = 0, K_EN_OFF = 1, K_EN_ON = 2, K_RST = 3, K_CLR = 4;

   logic clk = 1'b0;
   logic rst, enable, bclk, lrclk, sdata, err_clr;
   logic [23:0] out0, out1;
   logic v0, v1, e0, e1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_rise_cyc = 0;
   int width_err = 0;
   logic p0 = 1'b0, p1 = 1'b0;
   logic [23:0] q0[$];
   logic [23:0] q1[$];
   int qc1[$];
   int q_rclose[$];
   logic [23:0] rs_out;
   logic rs_v, rs_e, hold_e;
   logic [23:0] hold_out;

   always #10 clk = ~clk;

   i2s_rx_deserializer dut0 (
      .clk(clk), .rst(rst), .enable(enable), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
      .i2s_sdata(sdata), .err_clr(err_clr), .sample_out(out0), .sample_valid(v0),
      .frame_err(e0)
   );

   i2s_rx_deserializer #(.CHANNEL(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .i2s_bclk(bclk), .i2s_lrclk(lrclk),
      .i2s_sdata(sdata), .err_clr(err_clr), .sample_out(out1), .sample_valid(v1),
      .frame_err(e1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (v0) begin
         q0.push_back(out0);
         if (p0) width_err <= width_err + 1;
      end
      if (v1) begin
         q1.push_back(out1);
         qc1.push_back(cyc);
         if (p1) width_err <= width_err + 1;
      end
      p0 <= v0;
      p1 <= v1;
   end

   task automatic clear_q();
      q0.delete();
      q1.delete();
      qc1.delete();
      q_rclose.delete();
   endtask

   // One BCLK period: low phase (data/word-select change), then high phase.
   task automatic bit_period(input logic lr, input logic sd, input int kind);
      bclk = 1'b0;
      lrclk = lr;
      sdata = sd;
      if (kind == K_EN_OFF) enable = 1'b0;
      if (kind == K_EN_ON) enable = 1'b1;
      if (kind == K_RST) begin
         rst = 1'b1;
         @(negedge clk);
         rs_out = out0;
         rs_v = v0;
         rs_e = e0;
         rst = 1'b0;
         repeat (HALF - 1) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      bclk = 1'b1;
      last_rise_cyc = cyc;
      for (int j = 0; j < HALF; j++) begin
         @(negedge clk);
         if (kind == K_CLR) err_clr = (j == 2);
      end
   endtask

   // LRCLK flips on the slot's last period so that bit lands as the edge bit.
   task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits,
                            input logic pad, input int act_bit, input int act_kind);
      for (int k = 0; k < nbits; k++) begin
         bit_period((k == nbits - 1) ? ~lr : lr, (k < 24) ? data[23 - k] : pad,
                    (k == act_bit) ? act_kind : K_NONE);
         if (k == nbits - 1 && lr) q_rclose.push_back(last_rise_cyc);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                             input int lbits, input int rbits, input logic pad);
      send_slot(1'b0, l, lbits, pad, -1, K_NONE);
      send_slot(1'b1, r, rbits, pad, -1, K_NONE);
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (out0 !== 24'h0) begin n_fail++; $display("FAIL reset_out0: got %h want 000000", out0); end
      n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", v0); end
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL reset_err0: got %b want 0", e0); end
      n_checks++; if (out1 !== 24'h0) begin n_fail++; $display("FAIL reset_out1: got %h want 000000", out1); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_main();
      clear_q();
      for (int f = 0; f < 5; f++) send_frame(24'hA55AC3, 24'h123456, 32, 32, 1'b0);
      n_checks++; if (q0.size() !== 4) begin n_fail++; $display("FAIL main_count: got %0d want 4", q0.size()); end
      for (int i = 0; i < q0.size() && i < 4; i++) begin
         n_checks++; if (q0[i] !== 24'hA55AC3) begin n_fail++; $display("FAIL main_val[%0d]: got %h want a55ac3", i, q0[i]); end
      end
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL main_err: got %b want 0", e0); end
   endtask

   task automatic test_channel1();
      n_checks++; if (q1.size() !== 5) begin n_fail++; $display("FAIL ch1_count: got %0d want 5", q1.size()); end
      for (int i = 0; i < q1.size() && i < 5 && i < q_rclose.size(); i++) begin
         n_checks++; if (q1[i] !== 24'h123456) begin n_fail++; $display("FAIL ch1_val[%0d]: got %h want 123456", i, q1[i]); end
         n_checks++; if (qc1[i] - q_rclose[i] !== 4) begin n_fail++; $display("FAIL ch1_latency[%0d]: got %0d want 4", i, qc1[i] - q_rclose[i]); end
      end
   endtask

   task automatic test_sign_pad();
      clear_q();
      send_frame(24'h800001, 24'h000000, 32, 32, 1'b1);
      send_frame(24'h7FFFFF, 24'h000000, 32, 32, 1'b1);
      n_checks++; if (q0.size() !== 2) begin n_fail++; $display("FAIL sign_count: got %0d want 2", q0.size()); end
      if (q0.size() >= 2) begin
         n_checks++; if (q0[0] !== 24'h800001) begin n_fail++; $display("FAIL sign_neg: got %h want 800001", q0[0]); end
         n_checks++; if (q0[1] !== 24'h7FFFFF) begin n_fail++; $display("FAIL sign_pos: got %h want 7fffff", q0[1]); end
      end
   endtask

   task automatic test_frame_err();
      clear_q();
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", e0); end
      send_frame(24'hA55AC3, 24'h123456, 31, 32, 1'b0);
      n_checks++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL err_short: got %b want 1", e0); end
      n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL err_short_ch1: got %b want 1", e1); end
      n_checks++; if (q0.size() !== 0) begin n_fail++; $display("FAIL err_short_pulse: got %0d want 0", q0.size()); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", e0); end
      // Overlong slot whose closing edge coincides with err_clr: the set must win.
      send_slot(1'b0, 24'hA55AC3, 33, 1'b0, 32, K_CLR);
      n_checks++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", e0); end
      send_slot(1'b1, 24'h123456, 32, 1'b0, -1, K_NONE);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
      send_frame(24'hA55AC3, 24'h123456, 32, 32, 1'b0);
      n_checks++; if (q0.size() !== 1) begin n_fail++; $display("FAIL err_recover_count: got %0d want 1", q0.size()); end
      if (q0.size() >= 1) begin
         n_checks++; if (q0[0] !== 24'hA55AC3) begin n_fail++; $display("FAIL err_recover_val: got %h want a55ac3", q0[0]); end
      end
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL err_after_good: got %b want 0", e0); end
   endtask

   task automatic test_enable();
      clear_q();
      send_slot(1'b0, 24'h111111, 32, 1'b0, 10, K_EN_OFF);
      send_slot(1'b1, 24'h000000, 32, 1'b0, -1, K_NONE);
      send_frame(24'h222222, 24'h000000, 32, 32, 1'b0);
      send_slot(1'b0, 24'h333333, 32, 1'b0, 10, K_EN_ON);
      send_slot(1'b1, 24'h000000, 32, 1'b0, -1, K_NONE);
      n_checks++; if (q0.size() !== 0) begin n_fail++; $display("FAIL en_no_pulse: got %0d want 0", q0.size()); end
      n_checks++; if (out0 !== 24'hA55AC3) begin n_fail++; $display("FAIL en_hold: got %h want a55ac3", out0); end
      n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL en_err: got %b want 0", e0); end
      send_frame(24'h444444, 24'h000000, 32, 32, 1'b0);
      n_checks++; if (q0.size() !== 1) begin n_fail++; $display("FAIL en_resume_count: got %0d want 1", q0.size()); end
      if (q0.size() >= 1) begin
         n_checks++; if (q0[0] !== 24'h444444) begin n_fail++; $display("FAIL en_resume_val: got %h want 444444", q0[0]); end
      end
   endtask

   task automatic test_rst_mid_slot();
      clear_q();
      send_frame(24'h555555, 24'h000000, 30, 32, 1'b0);
      n_checks++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_err: got %b want 1", e0); end
      send_slot(1'b0, 24'h666666, 32, 1'b0, 20, K_RST);
      n_checks++; if (rs_out !== 24'h0) begin n_fail++; $display("FAIL rst_out: got %h want 000000", rs_out); end
      n_checks++; if (rs_v !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rs_v); end
      n_checks++; if (rs_e !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", rs_e); end
      send_slot(1'b1, 24'h000000, 32, 1'b0, -1, K_NONE);
      n_checks++; if (q0.size() !== 0) begin n_fail++; $display("FAIL rst_discard: got %0d want 0", q0.size()); end
      send_frame(24'h777777, 24'h000000, 32, 32, 1'b0);
      n_checks++; if (q0.size() !== 1) begin n_fail++; $display("FAIL rst_resume_count: got %0d want 1", q0.size()); end
      if (q0.size() >= 1) begin
         n_checks++; if (q0[0] !== 24'h777777) begin n_fail++; $display("FAIL rst_resume_val: got %h want 777777", q0[0]); end
      end
   endtask

   task automatic test_pulse_width();
      n_checks++; if (width_err !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d wide pulses want 0", width_err); end
   endtask

   initial begin
      test_reset();
      test_main();
      test_channel1();
      test_sign_pad();
      test_frame_err();
      test_enable();
      test_rst_mid_slot();
      test_pulse_width();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
